// File: rtl/uart_rx_core_pkg.sv
// uartPkg: shared types and constants for the uart_rx_core receiver.
// Holds the receive FSM state encoding, the bit positions of the status
// flags inside each FIFO word, and the trigger-level encodings.
package uartPkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK_WAIT
  } rx_state_e;

  // FIFO word layout: {break, framing err, parity err, data[7:0]}
  localparam int RD_W       = 11;
  localparam int RD_BRK_BIT = 10;
  localparam int RD_FE_BIT  = 9;
  localparam int RD_PE_BIT  = 8;

  // trig_lvl encodings
  localparam logic [1:0] TRIG_1  = 2'b00;
  localparam logic [1:0] TRIG_4  = 2'b01;
  localparam logic [1:0] TRIG_8  = 2'b10;
  localparam logic [1:0] TRIG_14 = 2'b11;

  // Trigger threshold in entries, clamped so a small FIFO can still trigger.
  function automatic int trig_level(input logic [1:0] enc, input int depth);
    int lvl;
    case (enc)
      TRIG_1:  lvl = 1;
      TRIG_4:  lvl = 4;
      TRIG_8:  lvl = 8;
      default: lvl = 14;
    endcase
    return (lvl > depth) ? depth : lvl;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through FIFO with occupancy count.
// The head word is visible on rd_data_o whenever the FIFO is non-empty.
// A push into a full FIFO only lands if a pop happens in the same cycle;
// clr_i overrides any simultaneous push or pop.
module uart_rx_fifo
  import uartPkg::*;
#(
  parameter int WIDTH = RD_W,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr, do_rd;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = empty_o ? '0 : mem[rd_ptr_q];

  // Pointer and count update; pointers wrap naturally (power-of-two depth)
  always_comb begin
    do_rd    = pop_i && !empty_o && !clr_i;
    do_wr    = push_i && (!full_o || pop_i) && !clr_i;
    wr_ptr_d = wr_ptr_q + AW'(do_wr);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);
    count_d  = count_q + CW'(do_wr) - CW'(do_rd);
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Pointer/count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, no reset needed: contents are only visible via count
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with runtime frame format,
// flag-carrying receive FIFO, trigger level and overrun reporting.
// Optional character timeout is compiled in with `define UART_RX_TIMEOUT_EN.
module uart_rx_core
  import uartPkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    lc_bits,
  input  logic                          lc_pe,
  input  logic                          lc_ep,
  input  logic                          lc_sp,
  input  logic [1:0]                    trig_lvl,
  input  logic                          fifo_clr,
  input  logic                          rx_i,
  input  logic                          rd_en,
  output logic [10:0]                   rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          trig_o,
  output logic                          overrun_o,
  output logic                          timeout_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(OVERSAMPLE);

  logic             sync1_q, sync2_q, rx_prev_q, rx_s;
  logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick, start_evt;
  rx_state_e        state_q, state_d;
  logic [SW-1:0]    samp_cnt_q, samp_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       data_q, data_d;
  logic             perr_q, perr_d;
  logic             any_one_q, any_one_d;
  logic             push;
  logic [RD_W-1:0]  push_word;
  logic             overrun_q, overrun_d;
  logic             fifo_full, fifo_empty;
  logic [2:0]       last_bit;
  logic             par_x, mid_bit, full_bit;

  assign rx_s      = sync2_q;
  assign start_evt = (state_q == ST_IDLE) && rx_prev_q && !rx_s;
  assign last_bit  = {1'b0, lc_bits} + 3'd4;
  assign par_x     = (^data_q) ^ rx_s;
  assign mid_bit   = tick && (samp_cnt_q == SW'(OVERSAMPLE/2 - 1));
  assign full_bit  = tick && (samp_cnt_q == SW'(OVERSAMPLE - 1));

  // Two-flop synchroniser plus previous-sample flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx_i;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  // Oversample tick: one-cycle pulse every baud_div clocks, realigned on a start edge
  always_comb begin
    tick       = (baud_div <= DIV_W'(1)) || (tick_cnt_q == baud_div - DIV_W'(1));
    tick_cnt_d = tick_cnt_q + DIV_W'(1);
    if (start_evt || tick) tick_cnt_d = '0;
  end

  // Tick counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt_q <= '0;
    else        tick_cnt_q <= tick_cnt_d;
  end

  // Receive FSM state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      samp_cnt_q <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      any_one_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      any_one_q  <= any_one_d;
    end
  end

  // Receive FSM next state: sample mid-start, then once per bit period
  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    perr_d     = perr_q;
    any_one_d  = any_one_q;
    push       = 1'b0;
    push_word  = '0;
    if (tick) samp_cnt_d = samp_cnt_q + SW'(1);
    case (state_q)
      ST_IDLE: begin
        if (start_evt) begin
          state_d    = ST_START;
          samp_cnt_d = '0;
          bit_cnt_d  = '0;
          data_d     = '0;
          perr_d     = 1'b0;
          any_one_d  = 1'b0;
        end
      end
      ST_START: begin
        if (mid_bit) begin
          samp_cnt_d = '0;
          state_d    = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (full_bit) begin
          samp_cnt_d        = '0;
          data_d[bit_cnt_q] = rx_s;
          any_one_d         = any_one_q | rx_s;
          bit_cnt_d         = bit_cnt_q + 3'd1;
          if (bit_cnt_q == last_bit) state_d = lc_pe ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (full_bit) begin
          samp_cnt_d = '0;
          any_one_d  = any_one_q | rx_s;
          if (lc_sp) perr_d = (rx_s == lc_ep);
          else       perr_d = lc_ep ? par_x : ~par_x;
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (full_bit) begin
          samp_cnt_d = '0;
          push       = 1'b1;
          if (!any_one_q && !rx_s) begin
            // Break: report only the break flag with zeroed data
            push_word[RD_BRK_BIT] = 1'b1;
            state_d               = ST_BRK_WAIT;
          end else begin
            push_word[7:0]       = data_q;
            push_word[RD_PE_BIT] = perr_q;
            push_word[RD_FE_BIT] = ~rx_s;
            state_d              = ST_IDLE;
          end
        end
      end
      ST_BRK_WAIT: begin
        if (tick && rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  uart_rx_fifo #(
    .WIDTH (RD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (fifo_clr),
    .push_i      (push),
    .push_data_i (push_word),
    .pop_i       (rd_en),
    .rd_data_o   (rd_data),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign rd_valid = ~fifo_empty;
  assign trig_o   = (fifo_count >= CW'(trig_level(trig_lvl, FIFO_DEPTH)));

  // Sticky overrun: set when a push is dropped, cleared only by a flush
  always_comb begin
    overrun_d = overrun_q;
    if (fifo_clr)                        overrun_d = 1'b0;
    else if (push && fifo_full && !rd_en) overrun_d = 1'b1;
  end

  // Overrun register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun_q <= 1'b0;
    else        overrun_q <= overrun_d;
  end
  assign overrun_o = overrun_q;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(48 * OVERSAMPLE + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d, to_thresh;
  logic            timeout_q, timeout_d;
  logic [3:0]      frame_bits;

  // Four frame times of silence while data waits in the FIFO
  assign frame_bits = {1'b0, last_bit} + 4'd3 + {3'b000, lc_pe};
  assign to_thresh  = TO_W'(frame_bits) * TO_W'(4 * OVERSAMPLE);

  // Timeout counter counts ticks since the last FIFO activity
  always_comb begin
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
    if (push || rd_en || fifo_empty)         to_cnt_d = '0;
    else if (tick && (to_cnt_q != to_thresh)) to_cnt_d = to_cnt_q + TO_W'(1);
    if (push || rd_en || fifo_clr)           timeout_d = 1'b0;
    else if (!fifo_empty && tick && (to_cnt_q == to_thresh - TO_W'(1)))
      timeout_d = 1'b1;
  end

  // Timeout registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed bench for uart_rx_core with a scoreboard queue.
// baud_div=3, OVERSAMPLE=16 -> 48 clk per bit.
module tb_uart_rx_core;

  localparam int BIT_CLK = 48;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud_div = 16'd3;
  logic [1:0]  lc_bits = 2'b11;
  logic        lc_pe = 1'b0, lc_ep = 1'b0, lc_sp = 1'b0;
  logic [1:0]  trig_lvl = 2'b11;
  logic        fifo_clr = 1'b0;
  logic        rx_i = 1'b1;
  logic        rd_en = 1'b0;
  logic [10:0] rd_data;
  logic        rd_valid;
  logic [4:0]  fifo_count;
  logic        trig_o, overrun_o, timeout_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int frame_start_cyc = 0;
  int rv_rise_cyc = -1;
  logic rv_prev = 1'b0;
  logic [10:0] exp_q[$];

  uart_rx_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_div   (baud_div),
    .lc_bits    (lc_bits),
    .lc_pe      (lc_pe),
    .lc_ep      (lc_ep),
    .lc_sp      (lc_sp),
    .trig_lvl   (trig_lvl),
    .fifo_clr   (fifo_clr),
    .rx_i       (rx_i),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fifo_count (fifo_count),
    .trig_o     (trig_o),
    .overrun_o  (overrun_o),
    .timeout_o  (timeout_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record the cycle at which rd_valid rises
  always begin
    @(posedge clk);
    #1;
    if (rd_valid && !rv_prev) rv_rise_cyc = cyc;
    rv_prev = rd_valid;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (BIT_CLK) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input int nb, input logic has_par,
                            input logic pbit, input logic stop);
    @(posedge clk);
    #1;
    frame_start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(data[i]);
    if (has_par) drive_bit(pbit);
    drive_bit(stop);
    rx_i = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 600; i++) begin
      if (rd_valid) break;
      @(posedge clk);
      #1;
    end
    check({tag, "_valid"}, rd_valid, 1'b1);
  endtask

  task automatic pop_check(input string tag);
    logic [10:0] exp;
    wait_valid(tag);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7FF;
    check(tag, rd_data, exp);
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", rd_valid, 1'b0);
    check("rst_count", fifo_count, 5'd0);
    check("rst_trig", trig_o, 1'b0);
    check("rst_overrun", overrun_o, 1'b0);
    check("rst_timeout", timeout_o, 1'b0);
    check("rst_rd_data", rd_data, 11'h000);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // 8N1 0xA5 with latency: 2 + 3*(8 + 9*16) + 1 = 459 clk
    lc_bits = 2'b11; lc_pe = 1'b0;
    rv_rise_cyc = -1;
    exp_q.push_back(11'h0A5);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    check("8n1_latency", rv_rise_cyc - frame_start_cyc, 459);
    check("8n1_count", fifo_count, 5'd1);
    pop_check("8n1_data");
    check("8n1_count_after_pop", fifo_count, 5'd0);

    // 7E1: wrong then correct parity
    lc_bits = 2'b10; lc_pe = 1'b1; lc_ep = 1'b1; lc_sp = 1'b0;
    exp_q.push_back(11'h155);
    send_frame(8'h55, 7, 1'b1, 1'b1, 1'b1);
    pop_check("7e1_bad_par");
    exp_q.push_back(11'h055);
    send_frame(8'h55, 7, 1'b1, 1'b0, 1'b1);
    pop_check("7e1_good_par");

    // Stick parity with lc_ep=0 expects a 1 parity bit
    lc_sp = 1'b1; lc_ep = 1'b0;
    exp_q.push_back(11'h055);
    send_frame(8'h55, 7, 1'b1, 1'b1, 1'b1);
    pop_check("7s1_stick");

    // 5O1: 0x1F has five ones, odd parity bit 0
    lc_bits = 2'b00; lc_sp = 1'b0; lc_ep = 1'b0;
    exp_q.push_back(11'h01F);
    send_frame(8'h1F, 5, 1'b1, 1'b0, 1'b1);
    pop_check("5o1_data");

    // Framing error: stop bit low with non-zero data
    lc_bits = 2'b11; lc_pe = 1'b0;
    exp_q.push_back(11'h23C);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
    pop_check("8n1_framing");

    // Break: 20 bit times low -> exactly one entry
    exp_q.push_back(11'h400);
    @(posedge clk);
    #1;
    rx_i = 1'b0;
    repeat (20 * BIT_CLK) @(posedge clk);
    #1;
    check("brk_count_low", fifo_count, 5'd1);
    rx_i = 1'b1;
    repeat (3 * BIT_CLK) @(posedge clk);
    #1;
    check("brk_count_high", fifo_count, 5'd1);
    pop_check("brk_data");

    // One-tick glitch -> false start
    rx_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_i = 1'b1;
    repeat (2 * BIT_CLK) @(posedge clk);
    #1;
    check("glitch_count", fifo_count, 5'd0);

    // Overrun: 17 characters, no reads
    trig_lvl = 2'b11;
    for (int i = 0; i < 17; i++) begin
      logic [7:0] d;
      d = 8'(i * 13 + 7);
      if (i < 16) exp_q.push_back({3'b000, d});
      send_frame(d, 8, 1'b0, 1'b0, 1'b1);
      if (i == 15) begin
        repeat (40) @(posedge clk);
        #1;
        check("ovr_full_no_flag", overrun_o, 1'b0);
      end
    end
    repeat (40) @(posedge clk);
    #1;
    check("ovr_count", fifo_count, 5'd16);
    check("ovr_flag", overrun_o, 1'b1);
    check("ovr_head", rd_data, exp_q[0]);
    check("ovr_trig14", trig_o, 1'b1);
    fifo_clr = 1'b1;
    @(posedge clk);
    #1;
    fifo_clr = 1'b0;
    exp_q.delete();
    check("clr_count", fifo_count, 5'd0);
    check("clr_overrun", overrun_o, 1'b0);
    check("clr_valid", rd_valid, 1'b0);

    // Trigger level 4
    trig_lvl = 2'b01;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({3'b000, 8'(8'h30 + i)});
      send_frame(8'(8'h30 + i), 8, 1'b0, 1'b0, 1'b1);
    end
    repeat (40) @(posedge clk);
    #1;
    check("trig_below", trig_o, 1'b0);
    exp_q.push_back(11'h033);
    send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    check("trig_at4", trig_o, 1'b1);
    pop_check("trig_pop0");
    check("trig_after_pop", trig_o, 1'b0);
    check("trig_count3", fifo_count, 5'd3);
    for (int i = 0; i < 3; i++) pop_check("trig_drain");

    // Character timeout
    rv_rise_cyc = -1;
    exp_q.push_back(11'h0C3);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
`ifdef UART_RX_TIMEOUT_EN
    begin
      int push_cyc;
      push_cyc = rv_rise_cyc;
      for (int i = 0; i < 2500; i++) begin
        if (timeout_o) break;
        @(posedge clk);
        #1;
      end
      check("to_high", timeout_o, 1'b1);
      check("to_delay", cyc - push_cyc, 1920);
      pop_check("to_data");
      check("to_cleared", timeout_o, 1'b0);
    end
`else
    repeat (2000) @(posedge clk);
    #1;
    check("to_tied_low", timeout_o, 1'b0);
    pop_check("to_data");
`endif

    // Asynchronous reset mid-frame discards everything immediately
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    check("mid_rst_pre_count", fifo_count, 5'd1);
    @(posedge clk);
    #1;
    drive_bit(1'b0);
    drive_bit(1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_count", fifo_count, 5'd0);
    check("mid_rst_valid", rd_valid, 1'b0);
    rx_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10 * BIT_CLK) @(posedge clk);
    #1;
    check("mid_rst_no_push", fifo_count, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
